// File: rtl/pre_if_fetch_ctrl.sv
// Pre-IF stage: next-PC selection, pipelined req/addr_ok/data_ok fetch master and
// an in-order return FIFO toward IF. Redirects squash everything not yet delivered.
module pre_if_fetch_ctrl #(
    parameter logic [31:0] RESET_PC        = 32'h1c000000,
    parameter int          PC_STEP         = 4,
    parameter int          MAX_OUTSTANDING = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        br_taken,
    input  logic [31:0] br_target,
    input  logic        ertn_flush,
    input  logic [31:0] ertn_pc,
    input  logic        excp_flush,
    input  logic [31:0] excp_pc,
    input  logic        stall,
    output logic        inst_req,
    output logic [31:0] inst_addr,
    input  logic        inst_addr_ok,
    input  logic        inst_data_ok,
    input  logic [31:0] inst_rdata,
    input  logic        fs_allowin,
    output logic        to_fs_valid,
    output logic [31:0] to_fs_pc,
    output logic [31:0] to_fs_inst,
    output logic        to_fs_adef
);

    localparam int              CW    = $clog2(MAX_OUTSTANDING + 1);
    localparam int              PW    = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam logic [CW:0]     MAX_C = (CW+1)'(MAX_OUTSTANDING);
    localparam logic [PW-1:0]   LAST  = PW'(MAX_OUTSTANDING - 1);

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == LAST) ? '0 : p + PW'(1);
    endfunction

    logic [31:0]   pc;
    logic [CW-1:0] inflight;
    logic [CW-1:0] discard;
    logic [CW-1:0] fifo_count;
    logic          req_hold;
    logic          adef_done;

    logic [31:0]   pcq [MAX_OUTSTANDING];
    logic [PW-1:0] pcq_wr, pcq_rd;

    logic [31:0]   fifo_pc   [MAX_OUTSTANDING];
    logic [31:0]   fifo_inst [MAX_OUTSTANDING];
    logic          fifo_adef [MAX_OUTSTANDING];
    logic [PW-1:0] fifo_wr, fifo_rd;

    logic          redirect;
    logic [31:0]   redirect_pc;
    logic          pc_aligned;
    logic          credit_ok;
    logic          fifo_space;
    logic          hs;
    logic          dok;
    logic          push_data;
    logic          adef_push;
    logic          fifo_push;
    logic          pop;
    logic [31:0]   push_pc;
    logic [31:0]   push_inst;

    always_comb begin
        redirect_pc = br_target;
        if (excp_flush)
            redirect_pc = excp_pc;
        else if (ertn_flush)
            redirect_pc = ertn_pc;
    end

    assign redirect   = excp_flush | ertn_flush | br_taken;
    assign pc_aligned = (pc[1:0] == 2'b00);
    assign credit_ok  = ({1'b0, inflight} + {1'b0, fifo_count}) < MAX_C;
    assign fifo_space = {1'b0, fifo_count} < MAX_C;

    // A request left pending by a missing addr_ok keeps its address even if stall rises.
    assign inst_req  = ~reset & ~redirect & pc_aligned & credit_ok & (~stall | req_hold);
    assign inst_addr = pc;

    assign hs        = inst_req & inst_addr_ok;
    assign dok       = inst_data_ok & (inflight != '0);
    assign push_data = dok & (discard == '0) & ~redirect;
    assign adef_push = ~redirect & ~pc_aligned & ~adef_done & (inflight == '0) & fifo_space;
    assign fifo_push = push_data | adef_push;
    assign push_pc   = adef_push ? pc : pcq[pcq_rd];
    assign push_inst = adef_push ? 32'h0 : inst_rdata;

    assign to_fs_valid = (fifo_count != '0);
    assign to_fs_pc    = fifo_pc[fifo_rd];
    assign to_fs_inst  = fifo_inst[fifo_rd];
    assign to_fs_adef  = to_fs_valid & fifo_adef[fifo_rd];
    assign pop         = to_fs_valid & fs_allowin;

    always_ff @(posedge clk) begin
        if (hs)
            pcq[pcq_wr] <= pc;
        if (fifo_push) begin
            fifo_pc[fifo_wr]   <= push_pc;
            fifo_inst[fifo_wr] <= push_inst;
            fifo_adef[fifo_wr] <= adef_push;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc         <= RESET_PC;
            inflight   <= '0;
            discard    <= '0;
            fifo_count <= '0;
            req_hold   <= 1'b0;
            adef_done  <= 1'b0;
            pcq_wr     <= '0;
            pcq_rd     <= '0;
            fifo_wr    <= '0;
            fifo_rd    <= '0;
        end else begin
            req_hold <= inst_req & ~inst_addr_ok;
            if (hs)
                pcq_wr <= ptr_inc(pcq_wr);
            if (dok)
                pcq_rd <= ptr_inc(pcq_rd);
            case ({hs, dok})
                2'b10:   inflight <= inflight + CW'(1);
                2'b01:   inflight <= inflight - CW'(1);
                default: ;
            endcase

            if (redirect) begin
                // Squashed fetches still return on the bus; count them so their data is dropped.
                pc         <= redirect_pc;
                adef_done  <= 1'b0;
                discard    <= inflight - CW'(dok);
                fifo_count <= '0;
                fifo_wr    <= '0;
                fifo_rd    <= '0;
            end else begin
                if (hs)
                    pc <= pc + 32'(PC_STEP);
                if (dok && discard != '0)
                    discard <= discard - CW'(1);
                if (adef_push)
                    adef_done <= 1'b1;
                if (fifo_push)
                    fifo_wr <= ptr_inc(fifo_wr);
                if (pop)
                    fifo_rd <= ptr_inc(fifo_rd);
                case ({fifo_push, pop})
                    2'b10:   fifo_count <= fifo_count + CW'(1);
                    2'b01:   fifo_count <= fifo_count - CW'(1);
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_pre_if_fetch_ctrl.sv
// Bench for pre_if_fetch_ctrl: directed scenarios plus randomized traffic, checked each
// cycle against a queue-based model of the bus and of the stream IF should receive.
module tb_pre_if_fetch_ctrl;

    localparam logic [31:0] RESET_PC = 32'h1c000000;
    localparam int          MAX      = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic        br_taken, ertn_flush, excp_flush, stall;
    logic [31:0] br_target, ertn_pc, excp_pc;
    logic        inst_req, inst_addr_ok, inst_data_ok;
    logic [31:0] inst_addr, inst_rdata;
    logic        fs_allowin, to_fs_valid, to_fs_adef;
    logic [31:0] to_fs_pc, to_fs_inst;

    pre_if_fetch_ctrl #(.RESET_PC(RESET_PC), .PC_STEP(4), .MAX_OUTSTANDING(MAX)) dut (
        .clk(clk), .reset(reset),
        .br_taken(br_taken), .br_target(br_target),
        .ertn_flush(ertn_flush), .ertn_pc(ertn_pc),
        .excp_flush(excp_flush), .excp_pc(excp_pc),
        .stall(stall),
        .inst_req(inst_req), .inst_addr(inst_addr),
        .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
        .fs_allowin(fs_allowin),
        .to_fs_valid(to_fs_valid), .to_fs_pc(to_fs_pc),
        .to_fs_inst(to_fs_inst), .to_fs_adef(to_fs_adef)
    );

    always #5 clk = ~clk;

    typedef struct { logic [31:0] addr; bit squashed; } bus_t;
    typedef struct { logic [31:0] pc; logic [31:0] inst; logic adef; } ent_t;

    bus_t        busq[$];
    ent_t        fifoq[$];
    logic [31:0] exp_pc;
    bit          held, adef_done;

    int n_cmp = 0;
    int n_err = 0;

    int p_aok, p_dok, p_alw, p_stall, p_redir;
    bit f_use, f_e, f_r, f_b;
    logic [31:0] f_ep, f_rp, f_bp;

    function automatic logic [31:0] mem(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h5a5a_c3c3;
    endfunction

    function automatic bit pct(input int p);
        return $urandom_range(0, 99) < p;
    endfunction

    function automatic logic [31:0] rand_tgt();
        logic [31:0] t;
        t = RESET_PC + 32'($urandom_range(0, 1023)) * 4;
        if (pct(15)) t = t + 32'($urandom_range(1, 3));
        return t;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic model_clear();
        busq.delete();
        fifoq.delete();
        exp_pc    = RESET_PC;
        held      = 0;
        adef_done = 0;
    endtask

    task automatic model_step();
        bit          redir, aligned, exp_req, deliver, hs;
        int          sb, sf;
        logic [31:0] tgt;
        bus_t        b;
        redir   = excp_flush | ertn_flush | br_taken;
        tgt     = excp_flush ? excp_pc : (ertn_flush ? ertn_pc : br_target);
        sb      = busq.size();
        sf      = fifoq.size();
        aligned = (exp_pc[1:0] == 2'b00);
        exp_req = !redir && aligned && (sb + sf < MAX) && (!stall || held);
        chk("inst_req", 32'(inst_req), 32'(exp_req));
        if (exp_req) chk("inst_addr", inst_addr, exp_pc);
        chk("to_fs_valid", 32'(to_fs_valid), 32'(sf > 0));
        if (sf > 0) begin
            chk("to_fs_pc", to_fs_pc, fifoq[0].pc);
            chk("to_fs_inst", to_fs_inst, fifoq[0].inst);
            chk("to_fs_adef", 32'(to_fs_adef), 32'(fifoq[0].adef));
        end
        deliver = (sf > 0) && fs_allowin;
        hs      = exp_req && inst_addr_ok;
        b       = '{32'h0, 1'b1};
        if (inst_data_ok) b = busq.pop_front();
        if (redir) begin
            fifoq.delete();
            foreach (busq[i]) busq[i].squashed = 1;
            exp_pc    = tgt;
            adef_done = 0;
            held      = 0;
        end else begin
            if (deliver) void'(fifoq.pop_front());
            if (inst_data_ok && !b.squashed) fifoq.push_back('{b.addr, mem(b.addr), 1'b0});
            if (hs) begin
                busq.push_back('{exp_pc, 1'b0});
                exp_pc = exp_pc + 4;
            end
            if (!aligned && !adef_done && sb == 0 && sf < MAX) begin
                fifoq.push_back('{exp_pc, 32'h0, 1'b1});
                adef_done = 1;
            end
            held = exp_req && !inst_addr_ok;
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
        inst_addr_ok = pct(p_aok);
        inst_data_ok = (busq.size() > 0) && pct(p_dok);
        inst_rdata   = inst_data_ok ? mem(busq[0].addr) : $urandom;
        fs_allowin   = pct(p_alw);
        stall        = pct(p_stall);
        if (f_use) begin
            excp_flush = f_e; excp_pc = f_ep;
            ertn_flush = f_r; ertn_pc = f_rp;
            br_taken   = f_b; br_target = f_bp;
            f_use = 0;
        end else begin
            excp_flush = pct(p_redir / 3); excp_pc   = rand_tgt();
            ertn_flush = pct(p_redir / 3); ertn_pc   = rand_tgt();
            br_taken   = pct(p_redir / 3); br_target = rand_tgt();
        end
        @(negedge clk);
        model_step();
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic force_redir(input bit e, input logic [31:0] ep, input bit r, input logic [31:0] rp,
                               input bit b, input logic [31:0] bp);
        f_use = 1; f_e = e; f_ep = ep; f_r = r; f_rp = rp; f_b = b; f_bp = bp;
        cycle();
    endtask

    task automatic set_knobs(input int aok, input int dk, input int alw, input int stl, input int rd);
        p_aok = aok; p_dok = dk; p_alw = alw; p_stall = stl; p_redir = rd;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        reset        = 1;
        inst_data_ok = 0;
        inst_addr_ok = 0;
        br_taken = 0; ertn_flush = 0; excp_flush = 0;
        #1;
        chk("rst_inst_req", 32'(inst_req), 32'h0);
        chk("rst_to_fs_valid", 32'(to_fs_valid), 32'h0);
        chk("rst_to_fs_adef", 32'(to_fs_adef), 32'h0);
        chk("rst_inst_addr", inst_addr, RESET_PC);
        model_clear();
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 0;
    endtask

    initial begin
        reset = 1;
        br_taken = 0; ertn_flush = 0; excp_flush = 0; stall = 0;
        br_target = 0; ertn_pc = 0; excp_pc = 0;
        inst_addr_ok = 0; inst_data_ok = 0; inst_rdata = 0; fs_allowin = 0;
        f_use = 0; f_e = 0; f_r = 0; f_b = 0; f_ep = 0; f_rp = 0; f_bp = 0;
        model_clear();
        #2;
        chk("init_inst_req", 32'(inst_req), 32'h0);
        chk("init_to_fs_valid", 32'(to_fs_valid), 32'h0);
        chk("init_to_fs_adef", 32'(to_fs_adef), 32'h0);
        @(posedge clk);
        #1;
        reset = 0;

        // streaming with a 1-cycle-latency bus
        set_knobs(100, 100, 100, 0, 0);
        run(30);

        // two in flight, then a branch squashes them
        set_knobs(100, 0, 0, 0, 0);
        run(4);
        force_redir(0, 0, 0, 0, 1, 32'h1c000100);
        set_knobs(100, 100, 100, 0, 0);
        run(12);

        // exception beats a same-cycle branch
        run(3);
        force_redir(1, 32'h1c008000, 0, 0, 1, 32'h1c000200);
        run(12);

        // IF back-pressure, then drain
        set_knobs(100, 100, 0, 0, 0);
        run(10);
        set_knobs(100, 100, 100, 0, 0);
        run(10);

        // misaligned target, then ertn recovers
        force_redir(0, 0, 0, 0, 1, 32'h1c000102);
        run(10);
        force_redir(0, 0, 1, 32'h1c000010, 0, 0);
        run(12);

        // reset with FIFO occupied and a fetch in flight
        set_knobs(100, 100, 0, 0, 0);
        run(2);
        set_knobs(100, 0, 0, 0, 0);
        run(2);
        do_reset();
        set_knobs(100, 100, 100, 0, 0);
        run(10);

        // randomized traffic
        for (int ph = 0; ph < 15; ph++) begin
            set_knobs($urandom_range(20, 100), $urandom_range(20, 100), $urandom_range(10, 100),
                      $urandom_range(0, 40), $urandom_range(0, 12));
            run(200);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
